// File: rtl/band_scale_pipe_if.sv
// Bundle of the frame-level signals between the filter bank, the band scaler
// and the band summer.
//   master : drives in_vld/pot/audio_in/sat_clr, receives scaled results
//   slave  : the scaler itself
// Packing: band b occupies [b*POT_W +: POT_W] of pot and [b*DATA_W +: DATA_W]
// of audio_in / scaled_out.
interface band_scale_pipe_if #(
  parameter int DATA_W    = 16,
  parameter int POT_W     = 12,
  parameter int NUM_BANDS = 4
);
  logic                          in_vld;
  logic [NUM_BANDS*POT_W-1:0]    pot;
  logic [NUM_BANDS*DATA_W-1:0]   audio_in;
  logic                          sat_clr;
  logic                          out_vld;
  logic [NUM_BANDS*DATA_W-1:0]   scaled_out;
  logic [NUM_BANDS-1:0]          sat_flag;
  logic [NUM_BANDS-1:0]          sat_sticky;

  modport master (
    output in_vld, pot, audio_in, sat_clr,
    input  out_vld, scaled_out, sat_flag, sat_sticky
  );

  modport slave (
    input  in_vld, pot, audio_in, sat_clr,
    output out_vld, scaled_out, sat_flag, sat_sticky
  );
endinterface

// File: rtl/band_scale_pipe.sv
// Multi-band pot-squared gain scaler, three register stages.
//   stage 1 : slew-limited gain update per band, audio captured
//   stage 2 : signed product audio * gain
//   stage 3 : arithmetic shift, saturation, flags
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every register
//   bus    : band_scale_pipe_if slave (in_vld, pot, audio_in, sat_clr in;
//            out_vld, scaled_out, sat_flag, sat_sticky out)
module band_scale_pipe #(
  parameter int DATA_W    = 16,
  parameter int POT_W     = 12,
  parameter int NUM_BANDS = 4,
  parameter int SHIFT     = 10,
  parameter int RAMP_STEP = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  band_scale_pipe_if.slave bus
);
  localparam int GAIN_W = POT_W + 1;
  localparam int DIFF_W = POT_W + 2;
  localparam int PROD_W = DATA_W + POT_W + 1;

  localparam logic signed [DIFF_W-1:0] STEP_D  = DIFF_W'(RAMP_STEP);
  localparam logic signed [GAIN_W-1:0] STEP_G  = GAIN_W'(RAMP_STEP);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (DATA_W - 1)));

  logic signed [GAIN_W-1:0] gain_q  [NUM_BANDS], gain_d  [NUM_BANDS];
  logic signed [DATA_W-1:0] audio_q [NUM_BANDS], audio_d [NUM_BANDS];
  logic signed [PROD_W-1:0] prod_q  [NUM_BANDS], prod_d  [NUM_BANDS];
  logic [NUM_BANDS*DATA_W-1:0] scaled_q, scaled_d;
  logic [NUM_BANDS-1:0]        sat_flag_q, sat_flag_d;
  logic [NUM_BANDS-1:0]        sat_sticky_q, sat_sticky_d;
  logic vld1_q, vld1_d, vld2_q, vld2_d, vld3_q, vld3_d;

  // Target is the upper half of pot^2; the step toward it is bounded so a
  // large pot move becomes a ramp rather than an audible jump.
  function automatic logic signed [GAIN_W-1:0] next_gain(
    input logic signed [GAIN_W-1:0] g,
    input logic [POT_W-1:0]         p
  );
    logic signed [GAIN_W-1:0] tgt;
    logic signed [DIFF_W-1:0] diff;
    logic signed [DIFF_W-1:0] mag;
    tgt  = GAIN_W'(((2 * POT_W)'(p) * (2 * POT_W)'(p)) >> POT_W);
    diff = DIFF_W'(tgt) - DIFF_W'(g);
    mag  = diff[DIFF_W-1] ? -diff : diff;
    if (RAMP_STEP == 0 || mag <= STEP_D) return tgt;
    else if (diff[DIFF_W-1])             return g - STEP_G;
    else                                 return g + STEP_G;
  endfunction

  // Returns {clamped, value}; shift is arithmetic so negatives floor.
  function automatic logic [DATA_W:0] sat_scale(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] s;
    s = p >>> SHIFT;
    if (s > SAT_MAX)      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (s < SAT_MIN) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                  return {1'b0, s[DATA_W-1:0]};
  endfunction

  always_comb begin
    vld1_d = bus.in_vld;
    vld2_d = vld1_q;
    vld3_d = vld2_q;
    scaled_d   = scaled_q;
    sat_flag_d = sat_flag_q;
    for (int b = 0; b < NUM_BANDS; b++) begin
      gain_d[b]  = gain_q[b];
      audio_d[b] = audio_q[b];
      prod_d[b]  = prod_q[b];
      if (bus.in_vld) begin
        gain_d[b]  = next_gain(gain_q[b], bus.pot[b*POT_W +: POT_W]);
        audio_d[b] = bus.audio_in[b*DATA_W +: DATA_W];
      end
      if (vld1_q) begin
        prod_d[b] = PROD_W'(audio_q[b]) * PROD_W'(gain_q[b]);
      end
      if (vld2_q) begin
        {sat_flag_d[b], scaled_d[b*DATA_W +: DATA_W]} = sat_scale(prod_q[b]);
      end
    end
    // A fresh saturation overrides a simultaneous clear.
    sat_sticky_d = (bus.sat_clr ? '0 : sat_sticky_q) | (vld2_q ? sat_flag_d : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q       <= 1'b0;
      vld2_q       <= 1'b0;
      vld3_q       <= 1'b0;
      scaled_q     <= '0;
      sat_flag_q   <= '0;
      sat_sticky_q <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        gain_q[b]  <= '0;
        audio_q[b] <= '0;
        prod_q[b]  <= '0;
      end
    end else begin
      vld1_q       <= vld1_d;
      vld2_q       <= vld2_d;
      vld3_q       <= vld3_d;
      scaled_q     <= scaled_d;
      sat_flag_q   <= sat_flag_d;
      sat_sticky_q <= sat_sticky_d;
      for (int b = 0; b < NUM_BANDS; b++) begin
        gain_q[b]  <= gain_d[b];
        audio_q[b] <= audio_d[b];
        prod_q[b]  <= prod_d[b];
      end
    end
  end

  assign bus.out_vld    = vld3_q;
  assign bus.scaled_out = scaled_q;
  assign bus.sat_flag   = sat_flag_q;
  assign bus.sat_sticky = sat_sticky_q;
endmodule

// File: tb/tb_band_scale_pipe.sv
module tb_band_scale_pipe;
  localparam int DW = 16;
  localparam int PW = 12;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  band_scale_pipe_if #(.DATA_W(DW), .POT_W(PW), .NUM_BANDS(NB)) bus0 ();
  band_scale_pipe_if #(.DATA_W(DW), .POT_W(PW), .NUM_BANDS(NB)) bus1 ();

  band_scale_pipe #(.DATA_W(DW), .POT_W(PW), .NUM_BANDS(NB), .SHIFT(10), .RAMP_STEP(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  band_scale_pipe #(.DATA_W(DW), .POT_W(PW), .NUM_BANDS(NB), .SHIFT(10), .RAMP_STEP(64))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit sb_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: event missing or out of order", nm);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                  due;
    logic [NB*DW-1:0]    sc;
    logic [NB-1:0]       fl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int gm0[NB];
  int gm1[NB];
  logic [NB-1:0] stk0, stk1;

  function automatic int target(input int p);
    return (p * p) / 4096;
  endfunction

  function automatic int ramp(input int g, input int t, input int step);
    if (step == 0) return t;
    if (t - g > step) return g + step;
    if (g - t > step) return g - step;
    return t;
  endfunction

  function automatic int scale(input int a, input int g, output bit sat);
    longint p, s;
    p = longint'(a) * longint'(g);
    if (p >= 0) s = p / 1024;
    else        s = -((-p + 1023) / 1024);
    sat = 1'b0;
    if (s > 32767)  begin s = 32767;  sat = 1'b1; end
    if (s < -32768) begin s = -32768; sat = 1'b1; end
    return int'(s);
  endfunction

  task automatic drive(input bit vld, input int pots[NB], input int auds[NB]);
    exp_t e0, e1;
    int v;
    bit s;
    bus0.in_vld = vld;
    bus1.in_vld = vld;
    for (int b = 0; b < NB; b++) begin
      bus0.pot[b*PW +: PW] = PW'(pots[b]);
      bus1.pot[b*PW +: PW] = PW'(pots[b]);
      bus0.audio_in[b*DW +: DW] = DW'(auds[b]);
      bus1.audio_in[b*DW +: DW] = DW'(auds[b]);
    end
    if (vld && sb_on) begin
      e0.due = cyc + 3;
      e1.due = cyc + 3;
      for (int b = 0; b < NB; b++) begin
        gm0[b] = ramp(gm0[b], target(pots[b]), 0);
        gm1[b] = ramp(gm1[b], target(pots[b]), 64);
        v = scale(auds[b], gm0[b], s);
        e0.sc[b*DW +: DW] = v[DW-1:0];
        e0.fl[b] = s;
        v = scale(auds[b], gm1[b], s);
        e1.sc[b*DW +: DW] = v[DW-1:0];
        e1.fl[b] = s;
      end
      q0.push_back(e0);
      q1.push_back(e1);
    end
  endtask

  task automatic set_vld(input bit v);
    bus0.in_vld = v;
    bus1.in_vld = v;
  endtask

  task automatic set_clr(input bit c);
    bus0.sat_clr = c;
    bus1.sat_clr = c;
  endtask

  task automatic mon(input int d, input logic v, input logic [NB*DW-1:0] sc,
                     input logic [NB-1:0] fl, input logic [NB-1:0] st);
    exp_t e;
    bit have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (v) begin
      if (!have || e.due != cyc) begin
        fail_now($sformatf("dut%0d_spurious_out_vld_cyc%0d", d, cyc));
      end else begin
        if (d == 0) begin void'(q0.pop_front()); stk0 = stk0 | e.fl; end
        else        begin void'(q1.pop_front()); stk1 = stk1 | e.fl; end
        check($sformatf("dut%0d_frame_cyc%0d", d, cyc), 96'({sc, fl, st}),
              96'({e.sc, e.fl, (d == 0) ? stk0 : stk1}));
      end
    end else if (have && e.due <= cyc) begin
      fail_now($sformatf("dut%0d_missing_out_vld_cyc%0d", d, cyc));
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_on) begin
      mon(0, bus0.out_vld, bus0.scaled_out, bus0.sat_flag, bus0.sat_sticky);
      mon(1, bus1.out_vld, bus1.scaled_out, bus1.sat_flag, bus1.sat_sticky);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_vld(1'b0);
    set_clr(1'b0);
    q0.delete();
    q1.delete();
    for (int b = 0; b < NB; b++) begin gm0[b] = 0; gm1[b] = 0; end
    stk0 = '0;
    stk1 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called right after a driving negedge; returns edges until dut0 out_vld.
  task automatic wait_out(output int n);
    n = 0;
    while (n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) set_vld(1'b0);
      if (bus0.out_vld) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         pot;
    int         aud;
    logic [DW-1:0] exp;
    logic       fl;
  } vec_t;

  vec_t tbl[8];
  int pots[NB];
  int auds[NB];
  int n;
  int seen;
  int ev;
  logic [DW-1:0] ev16;

  initial begin
    tbl[0] = '{4095,   1000, 16'd3998, 1'b0};
    tbl[1] = '{4095,  32767, 16'h7FFF, 1'b1};
    tbl[2] = '{4095, -32768, 16'h8000, 1'b1};
    tbl[3] = '{0,     12345, 16'h0000, 1'b0};
    tbl[4] = '{64,       -1, 16'hFFFF, 1'b0};
    tbl[5] = '{64,        1, 16'h0000, 1'b0};
    tbl[6] = '{2048,     -7, 16'hFFF9, 1'b0};
    tbl[7] = '{1000,  -3000, 16'hFD35, 1'b0};

    set_vld(1'b0);
    set_clr(1'b0);
    bus0.pot = '0; bus1.pot = '0;
    bus0.audio_in = '0; bus1.audio_in = '0;
    stk0 = '0; stk1 = '0;
    #1;
    check("reset_state", 96'({bus0.out_vld, bus0.scaled_out, bus0.sat_flag, bus0.sat_sticky}), 96'(0));
    check("reset_state_ramp", 96'({bus1.out_vld, bus1.scaled_out, bus1.sat_flag, bus1.sat_sticky}), 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-frame vectors on the no-ramp instance.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin pots[b] = tbl[i].pot; auds[b] = tbl[i].aud; end
      drive(1'b1, pots, auds);
      wait_out(n);
      check($sformatf("vec%0d_latency", i), 96'(n), 96'(3));
      check($sformatf("vec%0d_out", i), 96'({bus0.scaled_out, bus0.sat_flag}),
            96'({{NB{tbl[i].exp}}, {NB{tbl[i].fl}}}));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_hold", i), 96'({bus0.out_vld, bus0.scaled_out, bus0.sat_flag}),
            96'({1'b0, {NB{tbl[i].exp}}, {NB{tbl[i].fl}}}));
    end

    // Randomized frames against the model: 20 back-to-back, then gaps.
    do_reset();
    sb_on = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
        pots[b] = int'($urandom_range(0, 4095));
        auds[b] = int'(shortint'($urandom));
      end
      drive((i < 20) || ($urandom_range(0, 3) != 0), pots, auds);
    end
    @(negedge clk);
    set_vld(1'b0);
    repeat (5) @(negedge clk);
    sb_on = 0;
    check("drain_dut0", 96'(q0.size()), 96'(0));
    check("drain_dut1", 96'(q1.size()), 96'(0));

    // Ramp from 0 toward 4094; audio 1024 makes the output equal the gain.
    do_reset();
    for (int b = 0; b < NB; b++) begin pots[b] = 4095; auds[b] = 1024; end
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        ev = (k - 3 < 64) ? 64 * (k - 3) : 4094;
        ev16 = ev[DW-1:0];
        check($sformatf("ramp_frame%0d", k - 3), 96'({bus1.out_vld, bus1.scaled_out}),
              96'({1'b1, {NB{ev16}}}));
      end
      drive(k <= 64, pots, auds);
    end

    // Reset with two frames in flight.
    do_reset();
    for (int b = 0; b < NB; b++) begin pots[b] = 4095; auds[b] = 1000; end
    @(negedge clk); drive(1'b1, pots, auds);
    @(negedge clk); drive(1'b1, pots, auds);
    @(negedge clk);
    rst_n = 1'b0;
    set_vld(1'b0);
    #1;
    check("reset_mid_frame", 96'({bus0.out_vld, bus1.out_vld, bus0.scaled_out, bus1.sat_sticky}), 96'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus0.out_vld || bus1.out_vld) seen = 1;
    end
    check("flushed_frames_no_out_vld", 96'(seen), 96'(0));

    for (int b = 0; b < NB; b++) auds[b] = 1024;
    @(negedge clk); drive(1'b1, pots, auds);
    wait_out(n);
    check("gain_restart_ramp", 96'({bus1.out_vld, bus1.scaled_out}), 96'({1'b1, {NB{16'd64}}}));
    check("gain_restart_noramp", 96'({n[3:0], bus0.scaled_out}), 96'({4'd3, {NB{16'd4094}}}));

    // Saturation, sticky clear, and clear colliding with a new saturation.
    for (int b = 0; b < NB; b++) auds[b] = 32767;
    @(negedge clk); drive(1'b1, pots, auds);
    wait_out(n);
    check("sat_pos", 96'({bus0.scaled_out, bus0.sat_flag, bus0.sat_sticky}),
          96'({{NB{16'h7FFF}}, 4'hF, 4'hF}));
    @(negedge clk); set_clr(1'b1);
    @(negedge clk); set_clr(1'b0);
    check("sticky_cleared", 96'({bus0.sat_sticky, bus0.sat_flag}), 96'({4'h0, 4'hF}));

    for (int b = 0; b < NB; b++) auds[b] = -32768;
    @(negedge clk); drive(1'b1, pots, auds);
    @(negedge clk); set_vld(1'b0);
    @(negedge clk); set_clr(1'b1);
    @(negedge clk); set_clr(1'b0);
    check("clr_vs_set_set_wins", 96'({bus0.out_vld, bus0.scaled_out, bus0.sat_sticky}),
          96'({1'b1, {NB{16'h8000}}, 4'hF}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
